sw_fifo_writer: RTL and testbench

Write-side front end of the FIFO board design. It synchronises and debounces the slide switches and a push key. On each debounced key press it pushes one byte, or a burst of incrementing bytes, taken from the switches into the FIFO write port. It honours `fifo_full` with a stall timeout and reports how many bursts were aborted.

---
 rtl/sw_fifo_writer.sv | 132 +++++++++++++
 tb/tb_sw_fifo_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_fifo_writer.sv
// Write-side front end: synchronises switches and key, debounces the key, and
// pushes a single byte or an incrementing burst into a FIFO on each press.
module sw_fifo_writer #(
    parameter int DB_CYCLES = 1000000,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        key_wr,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic [7:0]  drop_cnt
);
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int STW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    // Abort on the full cycle that would bring the stall count to TIMEOUT-1.
    localparam logic [STW-1:0] ST_LAST = STW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    logic [15:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic           key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           key_db_q, key_db_d, key_db_prev_q, key_db_prev_d;
    state_t         state_q, state_d;
    logic [7:0]     data_q, data_d;
    logic [3:0]     remain_q, remain_d;
    logic [STW-1:0] stall_q, stall_d;
    logic [7:0]     drop_q, drop_d;
    logic           press;

    always_comb begin
        sw_s1_d       = sw;
        sw_s2_d       = sw_s1_q;
        key_s1_d      = key_wr;
        key_s2_d      = key_s1_q;
        key_db_prev_d = key_db_q;
        db_cnt_d      = '0;
        key_db_d      = key_db_q;
        if (key_s2_q != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = ~key_db_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    assign press = key_db_q & ~key_db_prev_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        remain_d = remain_q;
        stall_d  = stall_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    data_d   = sw_s2_q[7:0];
                    remain_d = sw_s2_q[15] ? sw_s2_q[11:8] : 4'd0;
                    stall_d  = '0;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (!fifo_full) begin
                    wr_en = 1'b1;
                    if (remain_q == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        data_d   = data_q + 8'd1;
                        remain_d = remain_q - 4'd1;
                        stall_d  = '0;
                    end
                end else if (stall_q == ST_LAST) begin
                    state_d = HOLD;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else begin
                    stall_d = stall_q + STW'(1);
                end
            end
            HOLD: begin
                if (!key_db_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            key_s1_q      <= 1'b0;
            key_s2_q      <= 1'b0;
            db_cnt_q      <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
            state_q       <= IDLE;
            data_q        <= 8'h00;
            remain_q      <= 4'd0;
            stall_q       <= '0;
            drop_q        <= 8'h00;
        end else begin
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            key_s1_q      <= key_s1_d;
            key_s2_q      <= key_s2_d;
            db_cnt_q      <= db_cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_prev_d;
            state_q       <= state_d;
            data_q        <= data_d;
            remain_q      <= remain_d;
            stall_q       <= stall_d;
            drop_q        <= drop_d;
        end
    end

    assign wr_data  = data_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_sw_fifo_writer.sv
// Bench for sw_fifo_writer: directed scenarios plus random presses, checked
// cycle by cycle against a queue-based behavioural model.
module tb_sw_fifo_writer;
    localparam int DB = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, key_wr, fifo_full;
    logic [15:0] sw;
    logic        wr_en, busy;
    logic [7:0]  wr_data, drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: words still owed for the current press live in m_q.
    logic [15:0] m_sw0, m_sw1;
    logic        m_k0, m_k1, m_db, m_db_prev;
    int          m_run, m_mode, m_stall, m_drop;
    logic [7:0]  m_q[$];
    logic [7:0]  wlog[$];

    sw_fifo_writer #(.DB_CYCLES(DB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sw(sw), .key_wr(key_wr), .fifo_full(fifo_full),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sw0 = '0; m_sw1 = '0; m_k0 = 1'b0; m_k1 = 1'b0;
        m_db = 1'b0; m_db_prev = 1'b0; m_run = 0;
        m_mode = 0; m_stall = 0; m_drop = 0;
        m_q.delete();
    endtask

    task automatic tick();
        logic exp_en;
        logic press;
        int   len;
        @(negedge clk);
        exp_en = (m_mode == 1) && !fifo_full;
        chk("wr_en", 32'(wr_en), 32'(exp_en));
        if (exp_en) chk("wr_data", 32'(wr_data), 32'(m_q[0]));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (wr_en === 1'b1) wlog.push_back(wr_data);
        @(posedge clk);
        cyc++;
        if (rst === 1'b0) begin
            model_reset();
        end else begin
            press = m_db && !m_db_prev;
            case (m_mode)
                0: if (press) begin
                    len = m_sw1[15] ? int'(m_sw1[11:8]) + 1 : 1;
                    m_q.delete();
                    for (int i = 0; i < len; i++) m_q.push_back(8'(int'(m_sw1[7:0]) + i));
                    m_stall = 0;
                    m_mode = 1;
                end
                1: if (!fifo_full) begin
                    void'(m_q.pop_front());
                    m_stall = 0;
                    if (m_q.size() == 0) m_mode = 2;
                end else begin
                    m_stall++;
                    if (m_stall == TO - 1) begin
                        m_q.delete();
                        m_mode = 2;
                        if (m_drop < 255) m_drop++;
                    end
                end
                default: if (!m_db) m_mode = 0;
            endcase
            m_db_prev = m_db;
            if (m_k1 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db = !m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_k1 = m_k0; m_k0 = key_wr;
            m_sw1 = m_sw0; m_sw0 = sw;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] exp_burst[4];
        logic [7:0] b;
        int k, rate, hold;

        rst = 1'b0; key_wr = 1'b0; fifo_full = 1'b0; sw = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'h00);
        chk("rst_drop", 32'(drop_cnt), 32'(0));
        rst = 1'b1;
        run(5);

        // Bounce rejection
        wlog.delete();
        sw = 16'h0042;
        for (int i = 0; i < 10; i++) begin
            key_wr = ~key_wr;
            run(2);
        end
        key_wr = 1'b1; run(10);
        key_wr = 1'b0; run(20);
        chk("bounce_count", 32'(wlog.size()), 32'(1));
        if (wlog.size() >= 1) chk("bounce_data", 32'(wlog[0]), 32'h42);

        // Burst wrapping through 0xFF
        wlog.delete();
        sw = 16'h83FE; key_wr = 1'b1; run(12);
        key_wr = 1'b0; run(20);
        exp_burst = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        chk("burst_count", 32'(wlog.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < wlog.size()) chk("burst_data", 32'(wlog[i]), 32'(exp_burst[i]));

        // Stall and resume mid-burst
        wlog.delete();
        sw = 16'h8210; key_wr = 1'b1;
        k = 0;
        while (wlog.size() == 0 && k < 40) begin tick(); k++; end
        chk("stall_first_word_seen", 32'(wlog.size()), 32'(1));
        fifo_full = 1'b1; run(5);
        fifo_full = 1'b0; run(10);
        key_wr = 1'b0; run(20);
        chk("stall_count", 32'(wlog.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            if (i < wlog.size()) chk("stall_data", 32'(wlog[i]), 32'(8'h10 + i));
        chk("stall_drop", 32'(drop_cnt), 32'(0));

        // Timeout abort, then saturation
        wlog.delete();
        fifo_full = 1'b1; sw = 16'h0055; key_wr = 1'b1; run(20);
        key_wr = 1'b0; run(12);
        chk("timeout_no_write", 32'(wlog.size()), 32'(0));
        chk("timeout_drop1", 32'(drop_cnt), 32'(1));
        for (int i = 0; i < 256; i++) begin
            key_wr = 1'b1; run(18);
            key_wr = 1'b0; run(10);
        end
        chk("timeout_drop_sat", 32'(drop_cnt), 32'(255));
        fifo_full = 1'b0;

        // Reset in the middle of a 16-word burst
        wlog.delete();
        b = 8'($urandom);
        sw = {8'h8F, b}; key_wr = 1'b1;
        k = 0;
        while (wlog.size() < 2 && k < 40) begin tick(); k++; end
        chk("midrst_two_words_seen", 32'(wlog.size()), 32'(2));
        rst = 1'b0; key_wr = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_wr_en", 32'(wr_en), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_wr_data", 32'(wr_data), 32'h00);
        chk("midrst_drop", 32'(drop_cnt), 32'(0));
        wlog.delete();
        run(30);
        chk("midrst_no_more_writes", 32'(wlog.size()), 32'(0));

        // Key held long: one write, next only after release and re-press
        wlog.delete();
        sw = {8'h00, 8'($urandom)};
        key_wr = 1'b1; run(100);
        key_wr = 1'b0; run(15);
        chk("held_one_write", 32'(wlog.size()), 32'(1));
        key_wr = 1'b1; run(12);
        key_wr = 1'b0; run(15);
        chk("held_repress_write", 32'(wlog.size()), 32'(2));

        // Random presses, bursts, bounce and back-pressure
        for (int n = 0; n < 40; n++) begin
            sw = 16'($urandom);
            case ($urandom_range(0, 2))
                0: rate = 0;
                1: rate = 30;
                default: rate = 90;
            endcase
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) begin
                key_wr = ~key_wr;
                fifo_full = ($urandom_range(0, 99) < rate);
                tick();
            end
            key_wr = 1'b1;
            hold = $urandom_range(6, 30);
            for (int i = 0; i < hold; i++) begin
                fifo_full = ($urandom_range(0, 99) < rate);
                tick();
            end
            key_wr = 1'b0;
            for (int i = 0; i < 40; i++) begin
                fifo_full = ($urandom_range(0, 99) < rate);
                tick();
            end
        end
        fifo_full = 1'b0;
        run(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
